rgmii_inband_status: RTL and testbench
======================================

Name: rgmii_inband_status

Overview:
- Decodes RGMII in-band link status that the PHY drives on RXD during inter-frame idle.
- Debounces the decoded status and drives the TSE MAC status inputs set_10 and set_1000.
- Also exports link, duplex and a change interrupt, which the Nios polls through a PIO.
- Clocked on the PCS/MAC rx clock. Sits between the RGMII rx DDR capture and the MAC status connection.

Parameters:
- STABLE_COUNT, 4: number of consecutive identical valid idle samples required before a new status is committed (range 2..255).
- TIMEOUT_CYCLES, 65535: idle-starvation watchdog, in clock cycles (16-bit counter).

Ports:
- clk_clk  in  1  rx clock (2.5/25/125 MHz, follows PHY speed)
- reset_reset_n  in  1  asynchronous active-low reset
- rx_data  in  4  rising-edge RXD nibble from the DDR capture
- rx_dv  in  1  decoded RX_CTL data-valid
- rx_err  in  1  decoded RX_CTL error (DV xor falling-edge CTL)
- set_10  out  1  to MAC: 10 Mb/s selected
- set_1000  out  1  to MAC: 1000 Mb/s selected
- link_up  out  1  committed link state
- full_duplex  out  1  committed duplex
- speed_code  out  2  committed speed: 00=10M, 01=100M, 10=1000M
- status_change  out  1  one-cycle pulse on any commit that changes outputs
- irq  out  1  sticky change flag
- irq_clear  in  1  clears irq

Behaviour:
- Sample validity: a cycle is a valid idle sample only when rx_dv=0 and rx_err=0 and rx_data[2:1]!=11.
  - Field decode: rx_data[0]=link, rx_data[2:1]=speed, rx_data[3]=duplex.
  - Reserved speed 11 is an invalid sample. It resets the run counter to 0 and clears the candidate-valid flag.
- Frame/error cycles (rx_dv=1 or rx_err=1) are neither valid nor invalid. Candidate and run counter hold.
- Candidate register holds {link, speed, duplex}.
  - A valid sample that differs from the candidate, or arrives with no valid candidate: load it and set run=1.
  - A valid sample equal to the candidate: run=run+1, saturating at STABLE_COUNT.
- Commit: in the cycle where run reaches STABLE_COUNT and candidate != committed, the committed register loads the candidate.
  - Outputs reflect the new value on the next edge, i.e. 1 cycle after the STABLE_COUNT-th matching sample.
  - status_change pulses high for exactly that same output-update cycle.
- FSM states:
  - DOWN: committed link=0.
    - Enter QUAL on the first valid sample with link=1.
  - QUAL: candidate link=1, run<STABLE_COUNT.
    - To UP on commit.
    - Back to DOWN if a link=0 sample replaces the candidate.
  - UP: committed link=1.
    - Differing candidates are qualified in place; outputs hold until commit.
    - To DOWN on commit of link=0 or on watchdog expiry.
- Watchdog:
  - 16-bit counter, cleared by every valid sample; counts only in UP.
  - Reaching TIMEOUT_CYCLES forces committed link=0 (speed and duplex unchanged), run=0, candidate invalid, state DOWN.
  - Pulses status_change.
- Output mapping:
  - set_10 = link_up & (speed_code==00).
  - set_1000 = link_up & (speed_code==10).
  - Both are 0 for 100M or when link is down.
- irq: set by status_change. irq_clear clears it. Same-cycle set and clear: set wins.
- Reset (async assert, released synchronously by an upstream synchroniser):
  - All outputs 0, speed_code=00, state DOWN.
  - Counters 0, candidate invalid.
- Committed value is never changed by a partial run. An interrupted run restarts from 1 on the next differing sample.

Test Plan:
- Reset, then 4 idle samples rx_data=1101 (link, 1000M, FD) -> set_1000=1, set_10=0, link_up=1, full_duplex=1, speed_code=10 one cycle after the 4th sample; status_change single pulse; irq=1.
- From 1000M FD, 3 samples of 0011 (100M HD) then 0101 -> no output change and no pulse. Then 4×0011 -> speed_code=01, set_1000=0, full_duplex=0.
- 2 samples of 1101, a 1000-cycle frame (rx_dv=1, rx_data random), then 2 more 1101 -> commit after the 4th valid sample; the frame does not reset the run.
- Valid run interrupted by rx_data=0110 (reserved speed) at sample 3 -> run restarts; commit needs 4 further samples.
- UP with TIMEOUT_CYCLES=100, rx_dv held 1 for 150 cycles -> link_up=0, set_1000=0 at cycle 100, status_change pulse, state DOWN.
- irq_clear asserted in the same cycle as status_change -> irq remains 1. Async reset asserted mid-QUAL -> all outputs 0 immediately.

Source files
------------

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status decoder: debounces the idle-time RXD status nibble
// and drives the MAC speed selects, link/duplex status and a sticky change interrupt.
module rgmii_inband_status #(
  parameter int unsigned STABLE_COUNT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_err,
  output logic       set_10,
  output logic       set_1000,
  output logic       link_up,
  output logic       full_duplex,
  output logic [1:0] speed_code,
  output logic       status_change,
  output logic       irq,
  input  logic       irq_clear
);

  typedef enum logic [1:0] {S_DOWN, S_QUAL, S_UP} state_t;

  localparam logic [7:0]  STABLE     = 8'(STABLE_COUNT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT_CYCLES - 1);

  // Status vectors are packed {link, speed[1:0], duplex}.
  state_t      r_state, w_state_n;
  logic [3:0]  r_cand, r_comm, w_sample, w_cand_n, w_comm_n;
  logic        r_cand_v, w_cand_v_n;
  logic [7:0]  r_run, w_run_n;
  logic [15:0] r_wd;
  logic        r_change, r_irq, r_set_10, r_set_1000;
  logic        w_idle, w_valid, w_invalid, w_new, w_commit, w_expire;

  always_comb begin
    w_idle    = ~rx_dv & ~rx_err;
    w_valid   = w_idle & (rx_data[2:1] != 2'b11);
    w_invalid = w_idle & (rx_data[2:1] == 2'b11);
    w_sample  = {rx_data[0], rx_data[2:1], rx_data[3]};
    w_new     = w_valid & (~r_cand_v | (w_sample != r_cand));
    w_expire  = (r_state == S_UP) & ~w_valid & (r_wd == TIMEOUT_M1);

    w_cand_n   = r_cand;
    w_cand_v_n = r_cand_v;
    w_run_n    = r_run;
    if (w_valid) begin
      if (w_new) begin
        w_cand_n   = w_sample;
        w_cand_v_n = 1'b1;
        w_run_n    = 8'd1;
      end else if (r_run != STABLE) begin
        w_run_n = r_run + 8'd1;
      end
    end else if (w_invalid | w_expire) begin
      w_cand_v_n = 1'b0;
      w_run_n    = '0;
    end

    // Commit is evaluated on the next-state run so outputs move on the edge
    // that consumes the STABLE_COUNT-th matching sample.
    w_commit = w_valid & (w_run_n == STABLE) & (w_cand_n != r_comm);
    w_comm_n = r_comm;
    if (w_commit) begin
      w_comm_n = w_cand_n;
    end else if (w_expire) begin
      w_comm_n[3] = 1'b0;
    end

    w_state_n = r_state;
    case (r_state)
      S_DOWN: begin
        if (w_commit & w_comm_n[3])        w_state_n = S_UP;
        else if (w_valid & w_sample[3])    w_state_n = S_QUAL;
      end
      S_QUAL: begin
        if (w_commit & w_comm_n[3])        w_state_n = S_UP;
        else if (w_new & ~w_sample[3])     w_state_n = S_DOWN;
        else if (w_invalid)                w_state_n = S_DOWN;
      end
      S_UP: begin
        if (w_expire)                      w_state_n = S_DOWN;
        else if (w_commit & ~w_comm_n[3])  w_state_n = S_DOWN;
      end
      default:                             w_state_n = S_DOWN;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= S_DOWN;
      r_cand     <= '0;
      r_cand_v   <= 1'b0;
      r_run      <= '0;
      r_comm     <= '0;
      r_wd       <= '0;
      r_change   <= 1'b0;
      r_irq      <= 1'b0;
      r_set_10   <= 1'b0;
      r_set_1000 <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cand     <= w_cand_n;
      r_cand_v   <= w_cand_v_n;
      r_run      <= w_run_n;
      r_comm     <= w_comm_n;
      r_wd       <= ((w_state_n == S_UP) && !w_valid) ? r_wd + 16'd1 : '0;
      r_change   <= w_commit | w_expire;
      r_irq      <= r_change | (r_irq & ~irq_clear);
      r_set_10   <= w_comm_n[3] & (w_comm_n[2:1] == 2'b00);
      r_set_1000 <= w_comm_n[3] & (w_comm_n[2:1] == 2'b10);
    end
  end

  assign link_up       = r_comm[3];
  assign speed_code    = r_comm[2:1];
  assign full_duplex   = r_comm[0];
  assign set_10        = r_set_10;
  assign set_1000      = r_set_1000;
  assign status_change = r_change;
  assign irq           = r_irq;

endmodule

// File: tb/tb_rgmii_inband_status.sv
// Scoreboard bench for rgmii_inband_status: a window-based reference model predicts
// every cycle's outputs; a monitor process compares them after each rising edge.
module tb_rgmii_inband_status;

  localparam int STABLE = 4;
  localparam int TOUT   = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rx_data = '0;
  logic       rx_dv = 1'b1;
  logic       rx_err = 1'b0;
  logic       irq_clear = 1'b0;
  logic       set_10, set_1000, link_up, full_duplex, status_change, irq;
  logic [1:0] speed_code;

  always #5 clk = ~clk;

  rgmii_inband_status #(.STABLE_COUNT(STABLE), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv),
    .rx_err(rx_err), .set_10(set_10), .set_1000(set_1000), .link_up(link_up),
    .full_duplex(full_duplex), .speed_code(speed_code),
    .status_change(status_change), .irq(irq), .irq_clear(irq_clear)
  );

  // Reference model: the most recent STABLE idle-cycle classifications (-1 = reserved speed).
  int         hist[$];
  logic [3:0] m_comm;          // {link, speed, duplex}
  int         m_idle;
  bit         m_chg, m_irq;
  logic [7:0] q[$];
  int         n_cmp = 0, n_bad = 0;

  function automatic logic [7:0] expect_vec(logic [3:0] c, bit chg, bit irq_v);
    return {c[3], c[0], c[2:1], c[3] && (c[2:1] == 2'b00), c[3] && (c[2:1] == 2'b10), chg, irq_v};
  endfunction

  function automatic logic [7:0] outs();
    return {link_up, full_duplex, speed_code, set_10, set_1000, status_change, irq};
  endfunction

  task automatic m_reset();
    hist.delete();
    m_comm = '0; m_idle = 0; m_chg = 0; m_irq = 0;
  endtask

  task automatic model_step(logic [3:0] d, bit dv, bit err, bit clr);
    bit idle = !dv && !err;
    bit valid = idle && (d[2:1] != 2'b11);
    int s = {28'd0, d[0], d[2:1], d[3]};
    bit chg = 0;
    bit stable;
    bit nirq = m_chg || (m_irq && !clr);
    if (idle) begin
      hist.push_back(valid ? s : -1);
      if (hist.size() > STABLE) void'(hist.pop_front());
    end
    if (valid) begin
      m_idle = 0;
      stable = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] != s) stable = 0;
      if (stable && s != int'(m_comm)) begin
        m_comm = s[3:0];
        chg = 1;
      end
    end else if (m_comm[3]) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_comm[3] = 1'b0;
        chg = 1;
        m_idle = 0;
        hist.delete();
      end
    end else begin
      m_idle = 0;
    end
    m_chg = chg;
    m_irq = nirq;
    q.push_back(expect_vec(m_comm, m_chg, m_irq));
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] d, bit dv, bit err, bit clr);
    @(negedge clk);
    rx_data = d; rx_dv = dv; rx_err = err; irq_clear = clr;
    model_step(d, dv, err, clr);
  endtask

  task automatic idle_n(logic [3:0] d, int n);
    repeat (n) drive(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(int n);
    repeat (n) drive(4'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic spot(string name, logic [7:0] exp);
    @(posedge clk);
    #2;
    check(name, outs(), exp);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 8'h00);
    m_reset();
    q.delete();
    rx_dv = 1'b1; irq_clear = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: outputs change every edge, so one expected vector per edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("scoreboard", outs(), e);
      end
    end
  end

  initial begin
    logic [3:0] pool [7];
    logic [3:0] cur;
    int r;
    pool = '{4'hD, 4'h3, 4'h5, 4'h0, 4'h6, 4'h9, 4'hB};
    m_reset();
    #2;
    check("reset_state", outs(), 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    idle_n(4'hD, 4);
    spot("link_1000fd", 8'b1_1_10_0_1_1_0);
    idle_n(4'hD, 1);
    spot("irq_after_change", 8'b1_1_10_0_1_0_1);

    idle_n(4'h3, 3);
    idle_n(4'h5, 1);
    spot("partial_run_hold", 8'b1_1_10_0_1_0_1);
    idle_n(4'h3, 4);
    spot("switch_100hd", 8'b1_0_01_0_0_1_1);

    idle_n(4'h0, 4);
    spot("link_down", 8'b0_0_00_0_0_1_1);

    idle_n(4'hD, 2);
    frame(1000);
    idle_n(4'hD, 2);
    spot("frame_keeps_run", 8'b1_1_10_0_1_1_1);

    idle_n(4'h9, 2);
    idle_n(4'h6, 1);
    idle_n(4'h9, 3);
    spot("reserved_restart", 8'b1_1_10_0_1_0_1);
    idle_n(4'h9, 1);
    spot("switch_10fd", 8'b1_1_00_1_0_1_1);

    frame(TOUT - 1);
    spot("watchdog_not_yet", 8'b1_1_00_1_0_0_1);
    frame(1);
    spot("watchdog_expire", 8'b0_1_00_0_0_1_1);
    frame(149 - TOUT);

    drive(4'h0, 1'b1, 1'b0, 1'b1);
    spot("irq_cleared", 8'b0_1_00_0_0_0_0);
    idle_n(4'hD, 4);
    drive(4'h0, 1'b1, 1'b0, 1'b1);
    spot("irq_set_wins", 8'b1_1_10_0_1_0_1);

    frame(TOUT + 10);
    idle_n(4'hD, 2);
    async_reset();

    cur = 4'hD;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r < 2) cur = pool[$urandom_range(0, 6)];
      if (r == 9) frame($urandom_range(1, 30));
      else if (r == 10) drive(4'($urandom), 1'b0, 1'b1, 1'b0);
      else if (r == 11 && $urandom_range(0, 3) == 0) frame($urandom_range(TOUT - 10, TOUT + 30));
      else begin
        int n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) drive(cur, 1'b0, 1'b0, $urandom_range(0, 7) == 0);
      end
    end
    drive(4'h0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
